// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, a dedicated $dst output,
// one write port with same-cycle bypass, and a sequential one-register-per-cycle clear.
module reg_file_mp #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DST_IDX = (2 ** ADDR_W) - 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] dst_out,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              write_ctrl,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_drop
);

    localparam int unsigned       DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_IDX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              idle_wr;
    logic              in_clear;

    always_comb begin
        in_clear = (state_q == S_CLEAR);
        idle_wr  = (state_q == S_IDLE) && write_ctrl;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart, no extension
                wr_drop_d = write_ctrl;
                if (ptr_q == LAST_A) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // A write accepted together with clr_req lands now; the clear reaches it later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (idle_wr) begin
            mem_q[wr_addr] <= wr_data;
        end else if (in_clear) begin
            mem_q[ptr_q] <= '0;
        end
    end

    always_comb begin
        rd_data_a = (idle_wr && (rd_addr_a == wr_addr)) ? wr_data : mem_q[rd_addr_a];
        rd_data_b = (idle_wr && (rd_addr_b == wr_addr)) ? wr_data : mem_q[rd_addr_b];
        dst_out   = (idle_wr && (DST_A == wr_addr))     ? wr_data : mem_q[DST_A];
        clr_busy  = in_clear;
        wr_drop   = wr_drop_q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_reg_file_mp;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] rd_addr_a = '0;
    logic [3:0] rd_addr_b = '0;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic [7:0] dst_out;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       write_ctrl = 1'b0;
    logic       clr_req = 1'b0;
    logic       clr_busy;
    logic       wr_drop;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 CLK = ~CLK;

    reg_file_mp #(
        .DATA_W (8),
        .ADDR_W (4),
        .DST_IDX(15)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .dst_out   (dst_out),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .write_ctrl(write_ctrl),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .wr_drop   (wr_drop)
    );

    // Behavioural model: array contents, number of clear cycles still to run, drop flag.
    logic [7:0] m_mem [16];
    int         m_clr_left = 0;
    bit         m_drop = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 8'd0;
            m_clr_left <= 0;
            m_drop     <= 1'b0;
        end else if (m_clr_left > 0) begin
            m_mem[16 - m_clr_left] <= 8'd0;
            m_clr_left             <= m_clr_left - 1;
            m_drop                 <= write_ctrl;
        end else begin
            m_drop <= 1'b0;
            if (write_ctrl) m_mem[wr_addr] <= wr_data;
            if (clr_req) m_clr_left <= 16;
        end
    end

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
        if (m_clr_left == 0 && write_ctrl && a == wr_addr) return wr_data;
        return m_mem[a];
    endfunction

    always @(negedge CLK) begin
        if (check_en) begin
            total++;
            if (rd_data_a !== exp_rd(rd_addr_a)) begin
                bad++;
                $display("FAIL model_rd_a t=%0t addr=%0d act=%0d exp=%0d", $time, rd_addr_a, rd_data_a, exp_rd(rd_addr_a));
            end
            total++;
            if (rd_data_b !== exp_rd(rd_addr_b)) begin
                bad++;
                $display("FAIL model_rd_b t=%0t addr=%0d act=%0d exp=%0d", $time, rd_addr_b, rd_data_b, exp_rd(rd_addr_b));
            end
            total++;
            if (dst_out !== exp_rd(4'd15)) begin
                bad++;
                $display("FAIL model_dst t=%0t act=%0d exp=%0d", $time, dst_out, exp_rd(4'd15));
            end
            total++;
            if (clr_busy !== (m_clr_left > 0)) begin
                bad++;
                $display("FAIL model_busy t=%0t act=%0b exp=%0b", $time, clr_busy, (m_clr_left > 0));
            end
            total++;
            if (wr_drop !== m_drop) begin
                bad++;
                $display("FAIL model_drop t=%0t act=%0b exp=%0b", $time, wr_drop, m_drop);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        write_ctrl = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        tick();
        write_ctrl = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            rd_addr_b = 4'(15 - a);
            at_neg();
            chk(nm, {rd_data_a, rd_data_b}, 32'd0);
        end
    endtask

    initial begin
        // Reset, then every address reads 0 on both ports
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_en = 1'b1;
        check_all_zero("reset_zero");
        chk("reset_busy", clr_busy, 0);
        chk("reset_drop", wr_drop, 0);
        chk("reset_dst", dst_out, 0);

        // Writes, overwrite and same-cycle bypass
        wr(4'd0, 8'd22);
        wr(4'd2, 8'd13);
        wr(4'd15, 8'd187);
        write_ctrl = 1'b1;
        wr_addr    = 4'd0;
        wr_data    = 8'd187;
        rd_addr_a  = 4'd0;
        at_neg();
        chk("bypass_r0", rd_data_a, 187);
        tick();
        write_ctrl = 1'b0;
        rd_addr_b  = 4'd2;
        at_neg();
        chk("rd_a_r0", rd_data_a, 187);
        chk("rd_b_r2", rd_data_b, 13);
        chk("dst_187", dst_out, 187);

        // Fill 1..16, clear with a dropped write and an ignored second clr_req
        for (int a = 0; a < 16; a++) wr(4'(a), 8'(a + 1));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            rd_addr_a  = (c == 0) ? 4'd0 : 4'(c - 1);
            rd_addr_b  = 4'(c);
            write_ctrl = (c == 3);
            wr_addr    = 4'd5;
            wr_data    = 8'd99;
            clr_req    = (c == 6);
            at_neg();
            chk("clear_busy", clr_busy, 1);
            if (c > 0) chk("clear_done_part", rd_data_a, 0);
            chk("clear_untouched", rd_data_b, 32'(c + 1));
            chk("clear_drop", wr_drop, (c == 4) ? 1 : 0);
            tick();
        end
        write_ctrl = 1'b0;
        clr_req    = 1'b0;
        at_neg();
        chk("clear_end_busy", clr_busy, 0);
        chk("clear_end_drop", wr_drop, 0);
        check_all_zero("clear_end_zero");

        // Reset aborts a clear in progress
        wr(4'd10, 8'd55);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (4) tick();
        rd_addr_a = 4'd10;
        at_neg();
        chk("abort_pre_r10", rd_data_a, 55);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        at_neg();
        chk("abort_busy", clr_busy, 0);
        check_all_zero("abort_zero");
        wr(4'd3, 8'd7);
        rd_addr_a = 4'd3;
        at_neg();
        chk("post_abort_r3", rd_data_a, 7);

        // Write and clr_req in the same idle cycle
        write_ctrl = 1'b1;
        wr_addr    = 4'd15;
        wr_data    = 8'd200;
        clr_req    = 1'b1;
        tick();
        write_ctrl = 1'b0;
        clr_req    = 1'b0;
        at_neg();
        chk("wc_dst_first", dst_out, 200);
        chk("wc_busy", clr_busy, 1);
        repeat (16) tick();
        at_neg();
        chk("wc_dst_end", dst_out, 0);
        chk("wc_busy_end", clr_busy, 0);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            RST        = ($urandom_range(0, 149) == 0);
            write_ctrl = $urandom_range(0, 1) == 1;
            clr_req    = ($urandom_range(0, 39) == 0);
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = 8'($urandom_range(0, 255));
            rd_addr_a  = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr_b  = ($urandom_range(0, 3) == 0) ? rd_addr_a : 4'($urandom_range(0, 15));
            tick();
        end
        RST        = 1'b0;
        write_ctrl = 1'b0;
        clr_req    = 1'b0;
        at_neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
